// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the accumulator stage, the 4-bit ALU and
// the benches that drive them.
//   state_e      - accumulator FSM state type (IDLE, EXEC, DONE), 2-bit
//   OP_*         - team ALU opcode constants
//   *_DEF        - default widths for data, select and operation counter
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned SELW_DEF  = 3;
  localparam int unsigned CNTW_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

endpackage

// File: rtl/alu_accumulator.sv
// alu_accumulator: command-driven accumulator feeding an external
// combinational ALU and writing its result back.
// One command per 3 cycles: accept (IDLE) -> write acc (EXEC) -> done (DONE).
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   cmd_valid/cmd_ready - command handshake
//   cmd_op/data/load    - opcode, operand B or load value, load select
//   alu_sel/a/b         - registered drive to the ALU
//   alu_y               - ALU result
//   acc, zero           - accumulator and its zero flag
//   done                - one-cycle pulse after each accumulator write
//   op_count            - saturating count of completed commands
module alu_accumulator
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SELW  = SELW_DEF,
  parameter int unsigned CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SELW-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_load,
  output logic [SELW-1:0]  alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] acc,
  output logic             zero,
  output logic             done,
  output logic [CNTW-1:0]  op_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [SELW-1:0]  op_q,    op_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             load_q,  load_d;
  logic [CNTW-1:0]  cnt_q,   cnt_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    data_d  = data_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          load_d  = cmd_load;
          state_d = EXEC;
        end
      end
      EXEC: begin
        acc_d = load_q ? data_q : alu_y;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      data_q  <= data_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs come from registers only; no cmd_* input reaches an output.
  assign cmd_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign alu_sel   = op_q;
  assign alu_a     = acc_q;
  assign alu_b     = data_q;
  assign acc       = acc_q;
  assign zero      = (acc_q == '0);
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_accumulator.sv
module tb_alu_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic       cmd_load;

  logic       cmd_ready, zero, done;
  logic [2:0] alu_sel;
  logic [3:0] alu_a, alu_b, alu_y, acc;
  logic [7:0] op_count;

  logic       s_cmd_ready, s_zero, s_done;
  logic [2:0] s_alu_sel;
  logic [3:0] s_alu_a, s_alu_b, s_alu_y, s_acc;
  logic [1:0] s_op_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'b000:  alu_f = a & b;
      3'b001:  alu_f = a | b;
      3'b010:  alu_f = a + b;
      3'b110:  alu_f = a - b;
      default: alu_f = a ^ b;
    endcase
  endfunction

  assign alu_y   = alu_f(alu_sel, alu_a, alu_b);
  assign s_alu_y = alu_f(s_alu_sel, s_alu_a, s_alu_b);

  alu_accumulator #(.WIDTH(4), .SELW(3), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_load(cmd_load),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .acc(acc), .zero(zero), .done(done), .op_count(op_count)
  );

  alu_accumulator #(.WIDTH(4), .SELW(3), .CNTW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_load(cmd_load),
    .alu_sel(s_alu_sel), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_y(s_alu_y),
    .acc(s_acc), .zero(s_zero), .done(s_done), .op_count(s_op_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a command's result is known the moment it is taken,
  // it lands one cycle later, is announced for one cycle, then the next
  // command may be taken.
  int         phase = 0;     // 0 free, 1 result pending, 2 announcing
  logic [3:0] m_acc = '0, m_pend = '0, m_data = '0;
  logic [2:0] m_op = '0;
  int         m_cnt = 0, m_cnt2 = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase = 0; m_acc = '0; m_pend = '0; m_data = '0; m_op = '0;
      m_cnt = 0; m_cnt2 = 0;
    end else begin
      case (phase)
        0: if (cmd_valid) begin
             m_pend = cmd_load ? cmd_data : alu_f(cmd_op, m_acc, cmd_data);
             m_op   = cmd_op;
             m_data = cmd_data;
             phase  = 1;
           end
        1: begin
             m_acc = m_pend;
             if (m_cnt  < 255) m_cnt++;
             if (m_cnt2 < 3)   m_cnt2++;
             phase = 2;
           end
        default: phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_ready",  {31'd0, cmd_ready},   {31'd0, phase == 0});
      chk("m_done",   {31'd0, done},        {31'd0, phase == 2});
      chk("m_acc",    {28'd0, acc},         {28'd0, m_acc});
      chk("m_zero",   {31'd0, zero},        {31'd0, m_acc == 4'd0});
      chk("m_count",  {24'd0, op_count},    m_cnt);
      chk("m_sel",    {29'd0, alu_sel},     {29'd0, m_op});
      chk("m_a",      {28'd0, alu_a},       {28'd0, m_acc});
      chk("m_b",      {28'd0, alu_b},       {28'd0, m_data});
      chk("m_s_acc",  {28'd0, s_acc},       {28'd0, m_acc});
      chk("m_s_done", {31'd0, s_done},      {31'd0, phase == 2});
      chk("m_s_cnt",  {30'd0, s_op_count},  m_cnt2);
    end
  end

  // Called on a negedge; returns on the negedge of the DONE cycle with
  // the ALU operands seen during EXEC.
  task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic ld,
                       output logic [3:0] ea, output logic [3:0] eb);
    int waited;
    cmd_op = op; cmd_data = d; cmd_load = ld; cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    ea = alu_a; eb = alu_b;
    @(negedge clk);
  endtask

  logic [3:0] ea, eb;
  logic [3:0] busy_exp [3];
  int         idx;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_load = 1'b0;
    @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_acc",   {28'd0, acc},       0);
    chk("rst_zero",  {31'd0, zero},      1);
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    chk("rst_done",  {31'd0, done},      0);
    chk("rst_count", {24'd0, op_count},  0);
    chk("rst_alu",   {21'd0, alu_sel, alu_a, alu_b}, 0);
    rst_n = 1'b1;

    // Load then add
    issue(alu_pkg::OP_ADD, 4'b0110, 1'b1, ea, eb);
    chk("load_acc",  {28'd0, acc}, 32'b0110);
    chk("load_done", {31'd0, done}, 1);
    issue(alu_pkg::OP_ADD, 4'b0001, 1'b0, ea, eb);
    chk("add_a",     {28'd0, ea}, 32'b0110);
    chk("add_b",     {28'd0, eb}, 32'b0001);
    chk("add_acc",   {28'd0, acc}, 32'b0111);
    chk("add_count", {24'd0, op_count}, 2);

    // Wrap-around
    issue(alu_pkg::OP_ADD, 4'b1111, 1'b1, ea, eb);
    issue(alu_pkg::OP_ADD, 4'b0001, 1'b0, ea, eb);
    chk("wrap_acc",  {28'd0, acc}, 0);
    chk("wrap_zero", {31'd0, zero}, 1);
    issue(alu_pkg::OP_SUB, 4'b0001, 1'b0, ea, eb);
    chk("sub_acc",   {28'd0, acc}, 32'b1111);
    chk("sub_zero",  {31'd0, zero}, 0);

    // Busy ignore: valid held for 9 cycles
    issue(alu_pkg::OP_ADD, 4'b0110, 1'b1, ea, eb);
    busy_exp[0] = 4'b0101; busy_exp[1] = 4'b0100; busy_exp[2] = 4'b0011;
    idx = 0;
    cmd_op = alu_pkg::OP_SUB; cmd_data = 4'b0001; cmd_load = 1'b0; cmd_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (done) begin
        if (idx < 3) chk("busy_acc", {28'd0, acc}, {28'd0, busy_exp[idx]});
        idx++;
      end
      if (i == 9) cmd_valid = 1'b0;
    end
    chk("busy_pulses", idx, 3);

    // Reset during EXEC
    issue(alu_pkg::OP_ADD, 4'b0110, 1'b1, ea, eb);
    cmd_op = alu_pkg::OP_ADD; cmd_data = 4'b0001; cmd_load = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    chk("mid_ready", {31'd0, cmd_ready}, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_acc",   {28'd0, acc}, 0);
    chk("mid_done",  {31'd0, done}, 0);
    chk("mid_count", {24'd0, op_count}, 0);
    @(negedge clk);
    chk("mid_done2", {31'd0, done}, 0);
    rst_n = 1'b1;

    // Counter saturation on the CNTW=2 instance
    for (int n = 1; n <= 5; n++) begin
      issue(alu_pkg::OP_OR, 4'(n), 1'b0, ea, eb);
      chk("sat_count", {30'd0, s_op_count}, (n > 3) ? 3 : n);
    end
    chk("sat_acc", {28'd0, s_acc}, 32'b0111);

    @(negedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
